// File: rtl/dut_sampler.sv
// Pin sampler: synchronizes raw DUT pins, compares them against expected values on
// sequencer strobes, keeps run statistics and logs {fail, data} into a capture FIFO.
module dut_sampler #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_bar,
    input  logic [WIDTH-1:0] dut_in,
    input  logic             start,
    input  logic             clr,
    input  logic [15:0]      num,
    input  logic             sample,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] mask,
    input  logic             rd_en,
    output logic [WIDTH:0]   rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             mismatch,
    output logic             fail,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_idx,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data;
    logic [15:0]      num_q;
    logic [15:0]      idx_q;
    logic             accept, fail_now, last;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd, drop;
    logic [WIDTH:0]   mem [DEPTH];

    // Raw pins feed nothing but the first synchronizer stage.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= dut_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign data     = sync_q[SYNC_STAGES-1];
    assign accept   = (state_q == S_RUN) && sample && !start && !clr;
    assign fail_now = |((data ^ exp) & mask);
    assign last     = accept && (num_q != 16'd0) && (idx_q + 16'd1 == num_q);

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (start)     state_d = S_RUN;
                else if (last) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            num_q     <= '0;
            idx_q     <= '0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            first_idx <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mismatch <= accept && fail_now;
            if (clr || start) begin
                num_q     <= clr ? 16'd0 : num;
                idx_q     <= '0;
                fail      <= 1'b0;
                err_cnt   <= '0;
                first_idx <= '0;
                overflow  <= 1'b0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (accept) begin
                    idx_q <= idx_q + 16'd1;
                    if (fail_now) begin
                        fail <= 1'b1;
                        if (!fail) first_idx <= idx_q;
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    end
                end
            end
        end
    end

    // Capture FIFO: extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty && !clr;
    assign do_wr = accept && (!full || do_rd);
    assign drop  = accept && full && !do_rd;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale contents on rd_data instead.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= {fail_now, data};
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_dut_sampler.sv
// Scoreboarded bench for dut_sampler: directed runs push expected FIFO entries,
// a monitor pops and compares them whenever the host reads the FIFO.
module tb_dut_sampler;

    logic       clk = 1'b0;
    logic       rst_bar, start, clr, sample, rd_en;
    logic [7:0] dut_in, exp_v, mask;
    logic [15:0] num;
    logic [8:0] rd_data;
    logic       empty, full, overflow, mismatch, fail, busy, done;
    logic [15:0] err_cnt, first_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int mm_seen = 0;
    int mm0;
    logic [8:0] sb [$];

    dut_sampler #(.WIDTH(8), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_bar(rst_bar), .dut_in(dut_in), .start(start), .clr(clr),
        .num(num), .sample(sample), .exp(exp_v), .mask(mask), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .overflow(overflow),
        .mismatch(mismatch), .fail(fail), .err_cnt(err_cnt), .first_idx(first_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Monitor: compares every real FIFO pop against the scoreboard head.
    always @(negedge clk) begin
        logic [8:0] want;
        if (rst_bar && mismatch) mm_seen++;
        if (rst_bar && rd_en && !empty && !clr) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL fifo_pop: got %0h, want no entry", rd_data);
            end else begin
                want = sb.pop_front();
                if (rd_data !== want) begin
                    n_bad++;
                    $display("FAIL fifo_pop: got %0h, want %0h", rd_data, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [7:0] v);
        dut_in = v;
        repeat (3) tick();
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic [7:0] e, input logic [7:0] m);
        sample = 1'b1;
        exp_v  = e;
        mask   = m;
        tick();
        sample = 1'b0;
    endtask

    task automatic do_read(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_mismatch"}, mismatch, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_idx"}, first_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst_bar = 1'b0; start = 1'b0; clr = 1'b0; sample = 1'b0; rd_en = 1'b0;
        dut_in = '0; exp_v = '0; mask = '0; num = '0;
        repeat (3) tick();
        check_reset_values("rst");
        rst_bar = 1'b1;
        tick();

        // All-pass run of three samples ending in DONE; a sample in DONE is ignored.
        set_pins(8'hA5);
        mm0 = mm_seen;
        do_start(16'd3);
        check("run1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            do_sample(8'hA5, 8'hFF);
            sb.push_back(9'h0A5);
        end
        check("run1_done", done, 1);
        check("run1_busy_low", busy, 0);
        check("run1_err_cnt", err_cnt, 0);
        check("run1_fail", fail, 0);
        do_sample(8'h00, 8'hFF);
        tick();
        check("run1_mm_count", mm_seen - mm0, 0);
        check("run1_done_ignore_err", err_cnt, 0);
        do_read(3);
        check("run1_drained", empty, 1);

        // Failures on the 2nd and 3rd samples.
        set_pins(8'h0F);
        mm0 = mm_seen;
        do_start(16'd3);
        do_sample(8'h0F, 8'hFF); sb.push_back(9'h00F);
        do_sample(8'h1F, 8'hFF); sb.push_back(9'h10F);
        check("run2_mm_pulse", mismatch, 1);
        do_sample(8'h1F, 8'hFF); sb.push_back(9'h10F);
        check("run2_err_cnt", err_cnt, 2);
        check("run2_first_idx", first_idx, 1);
        check("run2_fail", fail, 1);
        check("run2_done", done, 1);
        tick();
        check("run2_mm_count", mm_seen - mm0, 2);
        do_read(3);

        // Masking: mask 0 never fails; bit-7 check catches a flipped bit 7.
        do_start(16'd0);
        do_sample(8'hFF, 8'h00); sb.push_back(9'h00F);
        check("mask0_err_cnt", err_cnt, 0);
        set_pins(8'h8F);
        do_sample(8'h0F, 8'h80); sb.push_back(9'h18F);
        check("mask80_err_cnt", err_cnt, 1);
        check("mask80_first_idx", first_idx, 1);
        check("unlimited_busy", busy, 1);
        do_read(2);

        // Fill past DEPTH without reads: last two captures dropped.
        do_start(16'd0);
        for (int i = 0; i < 18; i++) begin
            do_sample(8'h0F, 8'hFF);
            if (i < 16) sb.push_back(9'h18F);
            if (i == 15) check("ovf_full_at_depth", full, 1);
            if (i == 15) check("ovf_not_yet", overflow, 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_err_cnt", err_cnt, 18);
        check("ovf_first_idx", first_idx, 0);
        do_start(16'd0);
        check("ovf_start_clears", overflow, 0);
        check("ovf_fifo_kept", full, 1);
        rd_en = 1'b1;
        do_sample(8'h8F, 8'hFF);
        rd_en = 1'b0;
        sb.push_back(9'h08F);
        check("rw_full_stays_full", full, 1);
        check("rw_full_no_ovf", overflow, 0);
        do_read(16);
        check("ovf_drained", empty, 1);
        do_read(1);
        check("rd_empty_data", rd_data, 0);
        check("rd_empty_flag", empty, 1);

        // Synchronizer latency: the third sample after a pin change is the first to see it.
        do_start(16'd0);
        dut_in = 8'h33;
        do_sample(8'h33, 8'hFF); sb.push_back(9'h18F);
        do_sample(8'h33, 8'hFF); sb.push_back(9'h18F);
        do_sample(8'h33, 8'hFF); sb.push_back(9'h033);
        check("sync_err_cnt", err_cnt, 2);
        do_read(3);

        // CLR beats START, SAMPLE and RD_EN in the same cycle.
        do_start(16'd0);
        do_sample(8'h33, 8'hFF); sb.push_back(9'h033);
        do_sample(8'h33, 8'hFF); sb.push_back(9'h033);
        clr = 1'b1; start = 1'b1; sample = 1'b1; rd_en = 1'b1; exp_v = 8'h00;
        tick();
        clr = 1'b0; start = 1'b0; sample = 1'b0; rd_en = 1'b0;
        sb.delete();
        check("clr_empty", empty, 1);
        check("clr_busy", busy, 0);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_mismatch", mismatch, 0);
        do_sample(8'h00, 8'hFF);
        check("idle_sample_ignored", empty, 1);

        // Reset mid-run with half-full FIFO.
        do_start(16'd0);
        for (int i = 0; i < 8; i++) begin
            do_sample(8'h00, 8'hFF);
            sb.push_back(9'h133);
        end
        check("pre_rst_err_cnt", err_cnt, 8);
        rst_bar = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        tick();
        rst_bar = 1'b1;
        tick();
        do_sample(8'h00, 8'hFF);
        check("post_rst_idle_empty", empty, 1);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_busy", busy, 0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
